// File: rtl/ram_access_ctrl_if.sv
// Request/response and RAM-side signal bundle for ram_access_ctrl.
// The slave modport is the controller. The master modport is the CPU
// execute stage together with the data RAM that the controller drives.
interface ram_access_ctrl_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
);
    // request side
    logic                     req;
    logic                     req_we;
    logic                     req_bit;
    logic                     req_ind;
    logic                     req_ri;
    logic [1:0]               psw_rs;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     req_wbit;

    // response side
    logic                     ready;
    logic                     done;
    logic                     err;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     rbit;

    // RAM side
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic                     ram_rd;
    logic                     ram_wr;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic                     ram_wbit;
    logic                     ram_is_bit;
    logic                     ram_ind;
    logic [DATA_WIDTH-1:0]    ram_rdata;
    logic                     ram_rbit;

    modport master (
        output req, req_we, req_bit, req_ind, req_ri, psw_rs,
               req_addr, req_wdata, req_wbit,
        input  ready, done, err, rdata, rbit,
        input  ram_addr, ram_rd, ram_wr, ram_wdata, ram_wbit, ram_is_bit, ram_ind,
        output ram_rdata, ram_rbit
    );

    modport slave (
        input  req, req_we, req_bit, req_ind, req_ri, psw_rs,
               req_addr, req_wdata, req_wbit,
        output ready, done, err, rdata, rbit,
        output ram_addr, ram_rd, ram_wr, ram_wdata, ram_wbit, ram_is_bit, ram_ind,
        input  ram_rdata, ram_rbit
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequencer between the CPU execute stage and the 256-byte internal data RAM.
// Handles one byte or bit access at a time, direct or register-indirect via
// R0/R1 of the selected bank. Indirection is resolved here by reading Ri
// first, so the RAM's own indirect flag is never used.
module ram_access_ctrl #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic             clock,
    input  logic             reset,
    ram_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_RD,
        S_PTR_WAIT,
        S_ACC,
        S_ACC_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_next;

    // latched request
    logic                     lat_we;
    logic                     lat_bit;
    logic                     lat_ind;
    logic                     lat_ri;
    logic [1:0]               lat_rs;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic                     lat_wbit;

    // pointer fetched from Ri
    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [ADDRESS_WIDTH-1:0] ptr_next;

    // registered outputs and their next values
    logic                     ready_q,  ready_n;
    logic                     done_q,   done_n;
    logic                     err_q,    err_n;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     rbit_q;
    logic [ADDRESS_WIDTH-1:0] addr_q,   addr_n;
    logic                     rd_q,     rd_n;
    logic                     wr_q,     wr_n;
    logic [DATA_WIDTH-1:0]    wdata_q,  wdata_n;
    logic                     wbit_q,   wbit_n;
    logic                     is_bit_q, is_bit_n;

    // effective request fields: live bus in IDLE, latched copy afterwards
    logic                     eff_we;
    logic                     eff_bit;
    logic                     eff_ind;
    logic                     eff_ri;
    logic [1:0]               eff_rs;
    logic [ADDRESS_WIDTH-1:0] eff_addr;
    logic [DATA_WIDTH-1:0]    eff_wdata;
    logic                     eff_wbit;

    logic accept;

    assign accept = (state == S_IDLE) && bus.req;

    // RAM strobes are registered, so the outputs for the next state are
    // decoded from state_next; in IDLE the latched copies are not loaded yet,
    // which is why the live request fields are selected there.
    always_comb begin
        if (state == S_IDLE) begin
            eff_we    = bus.req_we;
            eff_bit   = bus.req_bit;
            eff_ind   = bus.req_ind;
            eff_ri    = bus.req_ri;
            eff_rs    = bus.psw_rs;
            eff_addr  = bus.req_addr;
            eff_wdata = bus.req_wdata;
            eff_wbit  = bus.req_wbit;
        end else begin
            eff_we    = lat_we;
            eff_bit   = lat_bit;
            eff_ind   = lat_ind;
            eff_ri    = lat_ri;
            eff_rs    = lat_rs;
            eff_addr  = lat_addr;
            eff_wdata = lat_wdata;
            eff_wbit  = lat_wbit;
        end
    end

    // Pointer takes the Ri byte returned by the RAM during PTR_WAIT
    always_comb begin
        ptr_next = ptr;
        if (state == S_PTR_WAIT) begin
            ptr_next = ADDRESS_WIDTH'(bus.ram_rdata);
        end
    end

    // Next-state selection and next-cycle output decode
    always_comb begin
        state_next = state;
        addr_n     = '0;
        rd_n       = 1'b0;
        wr_n       = 1'b0;
        wdata_n    = '0;
        wbit_n     = 1'b0;
        is_bit_n   = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        ready_n    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.req) begin
                    if (bus.req_bit && bus.req_ind) begin
                        state_next = S_ERR;
                    end else if (bus.req_ind) begin
                        state_next = S_PTR_RD;
                    end else begin
                        state_next = S_ACC;
                    end
                end
            end
            S_PTR_RD:   state_next = S_PTR_WAIT;
            S_PTR_WAIT: state_next = S_ACC;
            S_ACC:      state_next = lat_we ? S_DONE : S_ACC_WAIT;
            S_ACC_WAIT: state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            S_ERR:      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase

        unique case (state_next)
            S_IDLE: ready_n = 1'b1;
            S_PTR_RD: begin
                addr_n = ADDRESS_WIDTH'({eff_rs, 2'b00, eff_ri});
                rd_n   = 1'b1;
            end
            S_ACC: begin
                addr_n   = eff_ind ? ptr_next : eff_addr;
                is_bit_n = eff_bit;
                if (eff_we) begin
                    wr_n    = 1'b1;
                    wdata_n = eff_wdata;
                    wbit_n  = eff_wbit;
                end else begin
                    rd_n = 1'b1;
                end
            end
            S_DONE:  done_n = 1'b1;
            S_ERR:   err_n  = 1'b1;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request on acceptance; later states use only these copies
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_bit   <= 1'b0;
            lat_ind   <= 1'b0;
            lat_ri    <= 1'b0;
            lat_rs    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wbit  <= 1'b0;
        end else if (accept) begin
            lat_we    <= bus.req_we;
            lat_bit   <= bus.req_bit;
            lat_ind   <= bus.req_ind;
            lat_ri    <= bus.req_ri;
            lat_rs    <= bus.psw_rs;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_wbit  <= bus.req_wbit;
        end
    end

    // Pointer register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Read result capture; held until the next read of the same kind
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            rbit_q  <= 1'b0;
        end else if (state == S_ACC_WAIT) begin
            if (lat_bit) begin
                rbit_q <= bus.ram_rbit;
            end else begin
                rdata_q <= bus.ram_rdata;
            end
        end
    end

    // Registered handshake and RAM outputs; reset drops the strobes at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            wbit_q   <= 1'b0;
            is_bit_q <= 1'b0;
        end else begin
            ready_q  <= ready_n;
            done_q   <= done_n;
            err_q    <= err_n;
            addr_q   <= addr_n;
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            wdata_q  <= wdata_n;
            wbit_q   <= wbit_n;
            is_bit_q <= is_bit_n;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.rbit       = rbit_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_rd     = rd_q;
    assign bus.ram_wr     = wr_q;
    assign bus.ram_wdata  = wdata_q;
    assign bus.ram_wbit   = wbit_q;
    assign bus.ram_is_bit = is_bit_q;
    assign bus.ram_ind    = 1'b0;

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Sequencer between the CPU execute stage and the internal 256-byte data RAM. It sits directly upstream of the RAM and drives its addr/rd/wr/in_data/in_bit/is_bit/indirect_flag pins.
- Accepts one byte or bit request at a time: direct, or register-indirect through R0/R1 of the active bank.
- Resolves indirect addressing itself by first reading Ri, then accessing the pointed byte. It returns read data with a one-cycle done pulse.

Parameters:
- ADDRESS_WIDTH, 8, RAM address width
- DATA_WIDTH, 8, byte width on request, response and RAM data paths

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req  in  1  request strobe; sampled only when ready=1
- req_we  in  1  1 = write, 0 = read
- req_bit  in  1  bit access; req_addr is a bit address
- req_ind  in  1  indirect byte access via Ri
- req_ri  in  1  selects R0 (0) or R1 (1) for indirect access
- psw_rs  in  2  register bank select (PSW.RS1:RS0), sampled with req
- req_addr  in  8  direct byte address, or bit address
- req_wdata  in  8  write byte
- req_wbit  in  1  write bit
- ready  out  1  1 when idle and able to accept req
- done  out  1  one-cycle pulse when the request completes
- err  out  1  one-cycle pulse, instead of done, for an illegal request
- rdata  out  8  read byte; held until the next accepted read
- rbit  out  1  read bit; held until the next accepted bit read
- ram_addr  out  8  to RAM addr
- ram_rd  out  1  to RAM rd
- ram_wr  out  1  to RAM wr
- ram_wdata  out  8  to RAM in_data
- ram_wbit  out  1  to RAM in_bit
- ram_is_bit  out  1  to RAM is_bit
- ram_ind  out  1  to RAM indirect_flag; tied 0 (indirection is resolved here)
- ram_rdata  in  8  from RAM out (registered; valid the cycle after rd)
- ram_rbit  in  1  from RAM out_bit (same timing)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except ready=1.
  - Latched request fields, rdata and rbit are cleared to 0.
- ram_rd and ram_wr are never 1 in the same cycle.
- ram_rd/ram_wr are registered outputs, asserted for exactly one cycle per access.
- States: IDLE, PTR_RD, PTR_WAIT, ACC, ACC_WAIT, DONE, ERR.
- IDLE:
  - ready=1.
  - On req=1, latch all req_* fields and psw_rs.
  - If req_bit=1 and req_ind=1, go to ERR; otherwise go to PTR_RD if req_ind=1, else ACC.
- PTR_RD:
  - ram_addr={3'b000, psw_rs, 2'b00, req_ri} (Ri address = 8*bank + i).
  - ram_rd=1, ram_is_bit=0.
- PTR_WAIT: capture ram_rdata into the pointer register, then go to ACC.
- ACC:
  - ram_addr = pointer (indirect) or latched req_addr (direct).
  - ram_is_bit = latched req_bit.
  - Write: ram_wr=1 with ram_wdata/ram_wbit; next state DONE.
  - Read: ram_rd=1; next state ACC_WAIT.
- ACC_WAIT: capture ram_rdata into rdata (byte) or ram_rbit into rbit (bit), then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, no RAM access, then IDLE.
- Latency, counted from the accept cycle (cycle 0) to the cycle done=1:
  - direct write: 2
  - direct read: 3
  - indirect write: 4
  - indirect read: 5
  - err: 1
- Back-to-back: ready=0 during DONE. A new req can be accepted in the IDLE cycle right after DONE. req while ready=0 is ignored (not queued).
- Indirect pointer values 0x00–0xFF are all legal; the full 256-byte RAM is addressable.
- rdata/rbit are not altered by writes or by err.
- Reset asserted mid-operation:
  - Aborts immediately and forces ram_rd/ram_wr to 0 asynchronously; no done or err.
  - A write whose ram_wr had already been sampled by the RAM is not undone.
- Request inputs may change freely after acceptance; only the latched copies are used.

Test Plan:
- Direct write 0x3C to 0x45, then direct read 0x45 -> done at cycle 2 for the write; done at cycle 3 with rdata=0x3C for the read; rd and wr never coincide.
- Bit write req_addr=0x0B, wbit=1 on a zeroed RAM, then byte read 0x21 -> rdata=0x08. A bit read of 0x0B then gives rbit=1.
- psw_rs=2, write 0x70 to 0x11 (R1 of bank 2), write 0xA5 to 0x70, then indirect read with req_ri=1 -> ram_addr sequence 0x11, 0x70; rdata=0xA5; done at cycle 5.
- Indirect write 0x5A via R0 (R0=0x90) -> RAM[0x90]=0x5A; ram_ind stays 0 throughout.
- req_bit=1 with req_ind=1 -> err pulse at cycle 1, no ram_rd/ram_wr, rdata unchanged.
- Assert reset during PTR_WAIT of an indirect write -> outputs go to reset values immediately, no wr to the target, ready=1 after release. A req held high while busy is not executed twice.
